fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the single-issue datapath.
//  Issues req/ready fetches to instruction memory and hands each instruction to decode via valid/accept.
//  Applies branch/jump/jr redirects from execute, using the PC+4, offset-add, shift-by-2 and sign-extend arithmetic.
//  Sits between imem and decode; it is the only writer of PC.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC loaded by reset; first fetch address
//  TIMEOUT_CYCLES  255            max cycles a request may wait for imem_ready before fetch_error (1..255)
// PORTS
//  clk               in   1   single clock, rising edge
//  reset             in   1   synchronous, active-low reset (0 = reset)
//  imem_req          out  1   fetch request; held until imem_ready
//  imem_addr         out  32  fetch address, stable while imem_req=1
//  imem_ready        in   1   one-cycle completion pulse; imem_rdata valid same cycle
//  imem_rdata        in   32  fetched instruction word
//  instr_valid       out  1   instr/instr_pc/instr_pc4 valid for decode
//  instr             out  32  instruction word
//  instr_pc          out  32  address of instr
//  instr_pc4         out  32  instr_pc + 4
//  instr_accept      in   1   decode takes instr when instr_valid & instr_accept & !stall
//  stall             in   1   hazard stall; freezes hand-off
//  redirect_valid    in   1   one-cycle redirect strobe from execute
//  redirect_type     in   2   0=BR, 1=J, 2=JR, 3=reserved (ignored)
//  branch_zero       in   1   Z flag; BR taken only when 1
//  redirect_base_pc  in   32  PC of redirecting instruction
//  redirect_imm      in   26  J target field; [15:0] = BR offset
//  redirect_reg      in   32  JR target register value
//  fetch_error       out  1   sticky imem timeout flag
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//    instr=0, instr_pc=0, instr_pc4=0, fetch_error=0, wait_cnt=0, pending target cleared. Mid-fetch reset drops the request.
//  States: IDLE, FETCH, HOLD, FLUSH, ERROR.
//   IDLE  -> FETCH next cycle (first imem_req 1 cycle after reset release).
//   FETCH: imem_req=1, imem_addr=pc. On imem_ready: latch instr=imem_rdata, instr_pc=pc, instr_pc4=pc+4;
//          pc<=pc+4; -> HOLD (instr_valid=1 the following cycle; fetch latency = ready cycle + 1).
//   HOLD:  instr_valid=1, imem_req=0. On instr_accept & !stall -> FETCH next cycle.
//          stall=1 holds outputs stable regardless of instr_accept.
//   FLUSH: imem_req stays 1 with old address until imem_ready; data discarded; pc<=pending target; -> FETCH.
//   ERROR: imem_req=0, instr_valid=0, fetch_error=1; left only by reset.
//  Redirect target (modular 32-bit, carries dropped):
//   BR: base+4 + (sext(imm[15:0])<<2), only if branch_zero=1; not-taken BR is a no-op.
//   J : {(base+4)[31:28], imm[25:0], 2'b00}.  JR: {reg[31:2], 2'b00}.  type 3: no-op.
//  Effective redirect (priority over all other events, any non-ERROR state):
//   HOLD: instr_valid=0 next cycle (accept same cycle is void), pc<=target, -> FETCH.
//   FETCH with imem_ready same cycle: data dropped, pc<=target, -> FETCH.
//   FETCH without imem_ready: pending<=target, -> FLUSH (no request abort).
//   FLUSH: pending overwritten (latest wins); with imem_ready same cycle, new target used.
//   IDLE: pc<=target, -> FETCH.
//  Timeout: wait_cnt increments each cycle imem_req=1 & !imem_ready, clears on ready/new request;
//   reaching TIMEOUT_CYCLES -> ERROR next cycle.
//  stall does not block an in-flight request or a redirect.
// STRUCTURE
//  Shared package fetch_pkg: state encoding, REDIR_BR/REDIR_J/REDIR_JR codes, 32'd4 constant.
//  Sub-module next_pc_calc (combinational): redirect target + taken flag from type/base/imm/reg/zero;
//   built from PC+4 adder, sign extend, shift-left-2 and jump concatenation.
//  Top: FSM, pc/pending/output registers, wait counter.
// TESTING
//  Reset release, imem_ready 2 cycles after each req, accept held 1 -> addrs 0x0,0x4,0x8; instr_valid 1 cycle after each ready.
//  HOLD, base=0x100, BR imm=16'hFFFE, zero=1 -> next imem_addr=0xFC; same with zero=0 -> stream unaffected.
//  FETCH in flight, J imm=26'h0000040, base=0x1000_0000 -> FLUSH, old data dropped, next addr=0x1000_0100.
//  FLUSH: JR reg=0x203 then J same-cycle-as-ready -> J target wins; JR low bits cleared (0x200) when alone.
//  HOLD with stall=1 and instr_accept=1 for 5 cycles -> outputs frozen, no imem_req; stall=0 -> fetch resumes.
//  imem_ready never arrives, TIMEOUT_CYCLES=4 -> fetch_error=1, imem_req=0 until reset=0; reset mid-FETCH -> IDLE, req=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, redirect kinds and PC step.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_FLUSH = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [1:0] REDIR_BR = 2'd0;
  localparam logic [1:0] REDIR_J  = 2'd1;
  localparam logic [1:0] REDIR_JR = 2'd2;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target: branch offset add, jump concatenation, register jump.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  redirect_type,
  input  logic [31:0] base_pc,
  input  logic [25:0] imm,
  input  logic [31:0] reg_val,
  input  logic        branch_zero,
  output logic [31:0] target,
  output logic        taken
);

  logic [31:0]        base_pc4;
  logic signed [15:0] br_off16;
  logic signed [31:0] br_off_sext;
  logic signed [31:0] br_off_shl;
  logic [31:0]        br_target;
  logic [31:0]        j_target;
  logic [31:0]        jr_target;

  assign base_pc4    = base_pc + PC_INC;
  assign br_off16    = imm[15:0];
  assign br_off_sext = {{16{br_off16[15]}}, br_off16};
  assign br_off_shl  = br_off_sext <<< 2;
  // Modular add: carries out of bit 31 are intentionally dropped.
  assign br_target   = base_pc4 + $unsigned(br_off_shl);
  assign j_target    = {base_pc4[31:28], imm, 2'b00};
  assign jr_target   = {reg_val[31:2], 2'b00};

  always_comb begin
    target = '0;
    taken  = 1'b0;
    case (redirect_type)
      REDIR_BR: begin
        target = br_target;
        taken  = branch_zero;
      end
      REDIR_J: begin
        target = j_target;
        taken  = 1'b1;
      end
      REDIR_JR: begin
        target = jr_target;
        taken  = 1'b1;
      end
      default: begin
        target = '0;
        taken  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: issues imem fetches, hands instructions to decode, applies redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_accept,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_type,
  input  logic        branch_zero,
  input  logic [31:0] redirect_base_pc,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_reg,
  output logic        fetch_error
);

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pending, pending_n;
  logic [31:0] instr_n, instr_pc_n, instr_pc4_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic [31:0] redir_target, pc_plus4;
  logic        redir_taken, redir_eff, timeout_hit;

  next_pc_calc u_next_pc (
    .redirect_type (redirect_type),
    .base_pc       (redirect_base_pc),
    .imm           (redirect_imm),
    .reg_val       (redirect_reg),
    .branch_zero   (branch_zero),
    .target        (redir_target),
    .taken         (redir_taken)
  );

  assign redir_eff   = redirect_valid & redir_taken;
  assign pc_plus4    = pc + PC_INC;
  assign imem_req    = (state == S_FETCH) || (state == S_FLUSH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign fetch_error = (state == S_ERROR);
  // This cycle would be the TIMEOUT_CYCLES-th without imem_ready.
  assign timeout_hit = imem_req && !imem_ready &&
                       (({1'b0, wait_cnt} + 9'd1) >= 9'(TIMEOUT_CYCLES));

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pending_n   = pending;
    instr_n     = instr;
    instr_pc_n  = instr_pc;
    instr_pc4_n = instr_pc4;
    wait_cnt_n  = '0;
    if (imem_req && !imem_ready)
      wait_cnt_n = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    unique case (state)
      S_IDLE: begin
        state_n = S_FETCH;
        if (redir_eff) pc_n = redir_target;
      end
      S_FETCH: begin
        if (redir_eff) begin
          if (imem_ready) begin
            pc_n = redir_target;
          end else begin
            pending_n = redir_target;
            state_n   = S_FLUSH;
          end
        end else if (imem_ready) begin
          instr_n     = imem_rdata;
          instr_pc_n  = pc;
          instr_pc4_n = pc_plus4;
          pc_n        = pc_plus4;
          state_n     = S_HOLD;
        end else if (timeout_hit) begin
          state_n = S_ERROR;
        end
      end
      S_HOLD: begin
        if (redir_eff) begin
          pc_n    = redir_target;
          state_n = S_FETCH;
        end else if (instr_accept && !stall) begin
          state_n = S_FETCH;
        end
      end
      // Old request must complete before the pending target is fetched.
      S_FLUSH: begin
        if (redir_eff) pending_n = redir_target;
        if (imem_ready) begin
          pc_n    = redir_eff ? redir_target : pending;
          state_n = S_FETCH;
        end else if (timeout_hit && !redir_eff) begin
          state_n = S_ERROR;
        end
      end
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      pending   <= '0;
      instr     <= '0;
      instr_pc  <= '0;
      instr_pc4 <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pending   <= pending_n;
      instr     <= instr_n;
      instr_pc  <= instr_pc_n;
      instr_pc4 <= instr_pc4_n;
      wait_cnt  <= wait_cnt_n;
    end
  end

endmodule
